// File: rtl/program_loader.sv
// Program loader: packs a valid/ready byte stream big-endian into 32-bit words and
// writes them to program memory while holding the CPU in reset. Optional: CHECKSUM_EN.
module program_loader #(
  parameter int MEMORY_DEPTH = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int COUNT_WIDTH  = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   Start,
  input  logic [COUNT_WIDTH-1:0] Word_Count,
  input  logic [7:0]             Byte_In,
  input  logic                   Byte_Valid,
  output logic                   Byte_Ready,
  output logic                   Write_Enable,
  output logic [DATA_WIDTH-1:0]  Write_Address,
  output logic [DATA_WIDTH-1:0]  Write_Data,
  output logic                   Busy,
  output logic                   Done,
  output logic                   Cpu_Hold,
  output logic                   Error,
  output logic [2:0]             dbg_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    WRITE   = 3'd2,
    CHECK   = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] depth_c = COUNT_WIDTH'(MEMORY_DEPTH);

  // Handshake: a byte moves only when Byte_Valid && Byte_Ready at a rising edge;
  // Byte_Ready is a function of state alone, never of Byte_Valid.

  state_t                 state, state_n;
  logic [1:0]             byte_cnt;
  logic [COUNT_WIDTH-1:0] word_idx;
  logic [COUNT_WIDTH-1:0] words_total;
  logic [23:0]            shift;
  logic                   accept;
  logic                   last_word;

  assign accept    = Byte_Valid && Byte_Ready;
  assign last_word = (word_idx == (words_total - COUNT_WIDTH'(1)));

  assign Byte_Ready   = (state == COLLECT) || (state == CHECK);
  assign Write_Enable = (state == WRITE);
  assign Busy         = (state == COLLECT) || (state == WRITE) || (state == CHECK);
  assign Done         = (state == DONE);
  assign Cpu_Hold     = (state != DONE);
  assign dbg_state    = state;

  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE: begin
        if (Start) state_n = (Word_Count == '0) ? DONE : COLLECT;
      end
      COLLECT: begin
        if (accept && (byte_cnt == 2'd3)) state_n = WRITE;
      end
      WRITE: begin
`ifdef CHECKSUM_EN
        state_n = last_word ? CHECK : COLLECT;
`else
        state_n = last_word ? DONE : COLLECT;
`endif
      end
      CHECK: begin
        if (accept) state_n = DONE;
      end
      default: state_n = IDLE;
    endcase
  end

`ifdef CHECKSUM_EN
  logic [7:0] csum;
  logic       error;
  assign Error = error;
`else
  assign Error = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      byte_cnt      <= '0;
      word_idx      <= '0;
      words_total   <= '0;
      shift         <= '0;
      Write_Address <= '0;
      Write_Data    <= '0;
`ifdef CHECKSUM_EN
      csum          <= '0;
      error         <= 1'b0;
`endif
    end else begin
      state <= state_n;
      case (state)
        IDLE, DONE: begin
          if (Start) begin
            byte_cnt    <= '0;
            word_idx    <= '0;
            words_total <= (Word_Count > depth_c) ? depth_c : Word_Count;
`ifdef CHECKSUM_EN
            csum        <= '0;
            error       <= 1'b0;
`endif
          end
        end
        COLLECT: begin
          if (accept) begin
            shift    <= {shift[15:0], Byte_In};
            byte_cnt <= byte_cnt + 2'd1;
`ifdef CHECKSUM_EN
            csum     <= csum ^ Byte_In;
`endif
            // Capture the full word now so address/data are stable through WRITE and hold afterwards.
            if (byte_cnt == 2'd3) begin
              Write_Data    <= DATA_WIDTH'({shift, Byte_In});
              Write_Address <= DATA_WIDTH'({word_idx, 2'b00});
            end
          end
        end
        WRITE: begin
          word_idx <= word_idx + COUNT_WIDTH'(1);
        end
        CHECK: begin
`ifdef CHECKSUM_EN
          if (accept && (Byte_In != csum)) error <= 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: scoreboard of expected {address,data} writes
// plus immediate-assertion checks on status outputs at each step.
module tb_program_loader;

  logic        clk;
  logic        reset;
  logic        Start;
  logic [5:0]  Word_Count;
  logic [7:0]  Byte_In;
  logic        Byte_Valid;
  logic        Byte_Ready;
  logic        Write_Enable;
  logic [31:0] Write_Address;
  logic [31:0] Write_Data;
  logic        Busy;
  logic        Done;
  logic        Cpu_Hold;
  logic        Error;
  logic [2:0]  dbg_state;

  program_loader dut (
    .clk(clk), .reset(reset), .Start(Start), .Word_Count(Word_Count),
    .Byte_In(Byte_In), .Byte_Valid(Byte_Valid), .Byte_Ready(Byte_Ready),
    .Write_Enable(Write_Enable), .Write_Address(Write_Address), .Write_Data(Write_Data),
    .Busy(Busy), .Done(Done), .Cpu_Hold(Cpu_Hold), .Error(Error), .dbg_state(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the head of the expected queue.
  always @(negedge clk) begin
    if (reset === 1'b1 && Write_Enable === 1'b1) begin
      wr_count++;
      if (exp_q.size() == 0) check("write_unexpected", 64'(wr_count), 64'(0));
      else check("write_addr_data", {Write_Address, Write_Data}, exp_q.pop_front());
    end
  end

  // Driver tasks (inputs change 1 time unit after the rising edge)
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; Start = 1'b0; Byte_Valid = 1'b0;
    tick(); tick();
    reset = 1'b1;
  endtask

  task automatic start_load(input logic [5:0] wc);
    Start = 1'b1; Word_Count = wc;
    tick();
    Start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int limit, output bit ok);
    logic rdy;
    ok = 1'b0;
    Byte_In = b; Byte_Valid = 1'b1;
    for (int i = 0; i < limit && !ok; i++) begin
      rdy = Byte_Ready;
      tick();
      if (rdy) ok = 1'b1;
    end
    Byte_Valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    bit ok;
    for (int k = 3; k >= 0; k--) begin
      send_byte(w[k*8 +: 8], 50, ok);
      if (!ok) check("byte_accept_timeout", 64'(ok), 64'(1));
      if (gap && k != 0) tick();
    end
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 200 && Done !== 1'b1; i++) tick();
    check(tag, 64'(Done), 64'(1));
  endtask

  initial begin
    bit ok;
    int base;
    Start = 1'b0; Word_Count = '0; Byte_In = '0; Byte_Valid = 1'b0; reset = 1'b0;

    // Reset state
    do_reset();
    check("rst_ready", 64'(Byte_Ready), 64'(0));
    check("rst_we", 64'(Write_Enable), 64'(0));
    check("rst_addr_data", {Write_Address, Write_Data}, 64'(0));
    check("rst_busy_done_err", {61'(0), Busy, Done, Error}, 64'(0));
    check("rst_hold", 64'(Cpu_Hold), 64'(1));

    // Test 1: two words, valid held high
    exp_q.push_back({32'h0, 32'h20080005});
    exp_q.push_back({32'h4, 32'h3C091001});
    start_load(6'd2);
    check("t1_busy", 64'(Busy), 64'(1));
    check("t1_hold", 64'(Cpu_Hold), 64'(1));
    send_word(32'h20080005, 1'b0);
    check("t1_strobe_latency", 64'(Write_Enable), 64'(1));
    send_word(32'h3C091001, 1'b0);
    wait_done("t1_done");
    check("t1_hold_released", 64'(Cpu_Hold), 64'(0));
    check("t1_writes", 64'(wr_count), 64'(2));
    check("t1_hold_last", {Write_Address, Write_Data}, {32'h4, 32'h3C091001});

    // Test 2: same load, valid toggling
    wr_count = 0;
    exp_q.push_back({32'h0, 32'h20080005});
    exp_q.push_back({32'h4, 32'h3C091001});
    start_load(6'd2);
    check("t2_done_cleared", 64'(Done), 64'(0));
    send_word(32'h20080005, 1'b1);
    send_word(32'h3C091001, 1'b1);
    wait_done("t2_done");
    check("t2_writes", 64'(wr_count), 64'(2));

    // Test 3: Word_Count=40 clamps to 32 words
    wr_count = 0;
    for (int i = 0; i < 32; i++) begin
      base = i * 4;
      exp_q.push_back({32'(i * 4), 8'(base), 8'(base + 1), 8'(base + 2), 8'(base + 3)});
    end
    start_load(6'd40);
    for (int i = 0; i < 128; i++) begin
      send_byte(8'(i), 50, ok);
      if (!ok) check("t3_byte_timeout", 64'(i), 64'(-1));
    end
    wait_done("t3_done");
    check("t3_writes", 64'(wr_count), 64'(32));
    check("t3_last_addr", 64'(Write_Address), 64'(32'h7C));
    check("t3_ready_low", 64'(Byte_Ready), 64'(0));
    send_byte(8'hEE, 10, ok);
    check("t3_surplus_rejected", 64'(ok), 64'(0));
    check("t3_queue_empty", 64'(exp_q.size()), 64'(0));

    // Test 4: reset after 6 bytes of a 3-word load, then reload one zero word
    wr_count = 0;
    exp_q.push_back({32'h0, 32'hA1B2C3D4});
    start_load(6'd3);
    send_word(32'hA1B2C3D4, 1'b0);
    send_byte(8'h55, 50, ok);
    send_byte(8'h66, 50, ok);
    reset = 1'b0;
    tick();
    check("t4_rst_outputs", {Write_Address, Write_Data}, 64'(0));
    check("t4_rst_status", {59'(0), Busy, Done, Error, Byte_Ready, Cpu_Hold}, 64'(1));
    reset = 1'b1;
    exp_q.push_back({32'h0, 32'h00000000});
    start_load(6'd1);
    send_word(32'h00000000, 1'b0);
    wait_done("t4_done");
    check("t4_writes", 64'(wr_count), 64'(2));

    // Test 5a: Start during COLLECT is ignored
    wr_count = 0;
    exp_q.push_back({32'h0, 32'h01020304});
    exp_q.push_back({32'h4, 32'h05060708});
    start_load(6'd2);
    send_byte(8'h01, 50, ok);
    send_byte(8'h02, 50, ok);
    start_load(6'd1);
    check("t5_still_busy", 64'(Busy), 64'(1));
    send_byte(8'h03, 50, ok);
    send_byte(8'h04, 50, ok);
    check("t5_not_done_after_word0", 64'(Done), 64'(0));
    send_word(32'h05060708, 1'b0);
    wait_done("t5_done");
    check("t5_writes", 64'(wr_count), 64'(2));

    // Test 5b: Word_Count=0 goes straight to DONE with no write
    do_reset();
    wr_count = 0;
    check("t5b_pre_done", 64'(Done), 64'(0));
    start_load(6'd0);
    check("t5b_done_next", 64'(Done), 64'(1));
    tick();
    check("t5b_no_write", 64'(wr_count), 64'(0));

`ifdef CHECKSUM_EN
    // Test 6: checksum byte matches, then mismatches
    wr_count = 0;
    exp_q.push_back({32'h0, 32'h11223344});
    start_load(6'd1);
    send_word(32'h11223344, 1'b0);
    send_byte(8'h44, 50, ok);
    check("t6_csum_accepted", 64'(ok), 64'(1));
    wait_done("t6_done_ok");
    check("t6_error_clear", 64'(Error), 64'(0));
    exp_q.push_back({32'h0, 32'h11223344});
    start_load(6'd1);
    send_word(32'h11223344, 1'b0);
    send_byte(8'h45, 50, ok);
    wait_done("t6_done_bad");
    check("t6_error_set", 64'(Error), 64'(1));
    check("t6_writes", 64'(wr_count), 64'(2));
`else
    // Without checksum: no extra byte consumed after the last word
    wr_count = 0;
    exp_q.push_back({32'h0, 32'h11223344});
    start_load(6'd1);
    send_word(32'h11223344, 1'b0);
    wait_done("t6_done");
    send_byte(8'h44, 10, ok);
    check("t6_no_csum_byte", 64'(ok), 64'(0));
    check("t6_error_zero", 64'(Error), 64'(0));
    check("t6_writes", 64'(wr_count), 64'(1));
`endif

    check("final_queue_empty", 64'(exp_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
